// File: rtl/fnd_pkg.sv
// Shared constants, segment codes and converter state encoding for the
// 4-digit FND display back end.
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int MAX_COUNT  = 9999;

    // Active-low segments {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter (14-bit binary -> 4 BCD digits) with a
// one-deep last-wins pending slot so a new count is never dropped while busy.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             busy,
    output logic [15:0]      bcd_out,
    output logic             bcd_update
);

    localparam logic [3:0]       LAST_STEP = 4'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_COUNT);

    conv_state_t      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [BIN_W-1:0] bin_sat;
    logic [15:0]      adj;

    always_comb begin
        bin_sat = (bin_in > MAX_BIN) ? MAX_BIN : bin_in;

        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        bcd_update = 1'b0;

        case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    bin_d   = bin_sat;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {adj[14:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_STEP) state_d = LOAD;
                if (bin_valid) begin
                    pend_d   = bin_sat;
                    pend_v_d = 1'b1;
                end
            end
            LOAD: begin
                bcd_update = 1'b1;
                bcd_d      = '0;
                cnt_d      = '0;
                pend_v_d   = 1'b0;
                // A strobe arriving with an empty slot is captured and consumed
                // in the same cycle, so busy never drops while work remains.
                if (pend_v_q) begin
                    bin_d   = pend_q;
                    state_d = CONV;
                    if (bin_valid) begin
                        pend_d   = bin_sat;
                        pend_v_d = 1'b1;
                    end
                end else if (bin_valid) begin
                    bin_d   = bin_sat;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign bcd_out = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Display back end: converts the count to BCD and time-multiplexes the four
// digits onto a common-anode 7-segment display with registered pins.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] count_in,
    input  logic             count_valid,
    input  logic [3:0]       dot_in,
    output logic             busy,
    output logic [3:0]       fnd_digit,
    output logic [7:0]       fnd_data
);

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [15:0]   bcd_out;
    logic          bcd_update;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   bcd_disp_q, bcd_disp_d;
    logic [3:0]    digit_q, digit_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    nib;
    logic [3:0]    lz;
    logic [7:0]    seg;

    bin2bcd_seq u_conv (
        .clk        (clk),
        .reset      (reset),
        .bin_in     (count_in),
        .bin_valid  (count_valid),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .bcd_update (bcd_update)
    );

    always_comb begin
        presc_d = presc_q + 1'b1;
        sel_d   = sel_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            sel_d   = sel_q + 2'd1;
        end

        bcd_disp_d = bcd_update ? bcd_out : bcd_disp_q;

        nib = bcd_disp_q[{sel_q, 2'b00} +: 4];
        // lz[i]: digit i and every digit above it are zero; ones never blanks.
        lz[3] = (bcd_disp_q[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd_disp_q[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd_disp_q[7:4] == 4'd0);
        lz[0] = 1'b0;

        seg     = bcd_to_seg(nib);
        digit_d = ~(4'b0001 << sel_q);
        data_d  = {~dot_in[sel_q], seg[6:0]};
        if ((BLANK_LZ != 0) && lz[sel_q]) data_d = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            sel_q      <= '0;
            bcd_disp_q <= '0;
            digit_q    <= 4'b1111;
            data_q     <= SEG_BLANK;
        end else begin
            presc_q    <= presc_d;
            sel_q      <= sel_d;
            bcd_disp_q <= bcd_disp_d;
            digit_q    <= digit_d;
            data_q     <= data_d;
        end
    end

    assign fnd_digit = digit_q;
    assign fnd_data  = data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: two instances (no blanking / blanking) share
// stimulus and are compared against a decimal-arithmetic display model.
module tb_fnd_scan_controller;

    localparam int SD = 4;

    logic        clk;
    logic        reset;
    logic [13:0] count_in;
    logic        count_valid;
    logic [3:0]  dot_in;
    logic        busy0, busy1;
    logic [3:0]  dig0, dig1;
    logic [7:0]  dat0, dat1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut0 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .dot_in(dot_in), .busy(busy0), .fnd_digit(dig0), .fnd_data(dat0)
    );

    fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut1 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .dot_in(dot_in), .busy(busy1), .fnd_digit(dig1), .fnd_data(dat1)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- checking and model ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Digit lit after the n-th edge since reset release.
    function automatic int model_sel(input int c);
        return ((c - 1) / SD) % 4;
    endfunction

    function automatic logic [7:0] model_data(input int val, input int sel,
                                              input logic [3:0] dots, input bit blank);
        int p = 1;
        logic [7:0] s;
        for (int i = 0; i < sel; i++) p = p * 10;
        if (blank && sel > 0 && val < p) return 8'hFF;
        s = seg_tab[(val / p) % 10];
        return {~dots[sel], s[6:0]};
    endfunction

    task automatic check_out(input string tag, input int val);
        int s;
        logic [3:0] one;
        logic [3:0] ed;
        s   = model_sel(cyc);
        one = 4'b0001;
        ed  = ~(one << s);
        check({tag, "_dig0"}, 32'(dig0), 32'(ed));
        check({tag, "_dig1"}, 32'(dig1), 32'(ed));
        check({tag, "_dat0"}, 32'(dat0), 32'(model_data(val, s, dot_in, 1'b0)));
        check({tag, "_dat1"}, 32'(dat1), 32'(model_data(val, s, dot_in, 1'b1)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        count_in    = 14'(v);
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy0), 32'd0);
    endtask

    task automatic frame(input string tag, input int val);
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            check_out(tag, val);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        int expv;
        int v;
        int nb;

        reset       = 1'b1;
        count_in    = '0;
        count_valid = 1'b0;
        dot_in      = 4'b0000;

        // Reset state and free-running scan
        #1;
        check("rst_dig", 32'(dig0), 32'hF);
        check("rst_dat", 32'(dat0), 32'hFF);
        check("rst_busy", 32'(busy0), 32'd0);
        #11;
        reset = 1'b0;
        for (int n = 0; n < 8 * SD; n++) begin
            tick();
            check_out("scan", 0);
        end

        // Single conversion: busy width and display latency
        send(1234);
        bc = 0;
        while (busy0 && bc < 100) begin
            bc++;
            tick();
        end
        check("busy_len", 32'(bc), 32'd15);
        check_out("lat_old", 0);
        tick();
        check_out("lat_new", 1234);
        frame("conv1234", 1234);

        // Saturation
        send(12000);
        wait_idle("sat1");
        tick();
        frame("sat12000", 9999);
        send(16383);
        wait_idle("sat2");
        tick();
        frame("sat16383", 9999);

        // Last-wins pending: 5678 at E0, 42 at E3, 7 at E6
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            count_valid = (k == 0 || k == 3 || k == 6);
            count_in    = (k == 0) ? 14'd5678 : (k == 3) ? 14'd42 : 14'd7;
            tick();
            count_valid = 1'b0;
            if (busy0) bc++;
            expv = (k < 16) ? 9999 : (k < 31) ? 5678 : 7;
            check_out("pend", expv);
        end
        check("pend_busy", 32'(bc), 32'd30);

        // Blanking and decimal point
        send(0);
        wait_idle("blank0");
        tick();
        frame("blank0", 0);
        dot_in = 4'b0010;
        send(1234);
        wait_idle("dp");
        tick();
        frame("dp1234", 1234);
        dot_in = 4'b0000;
        send(7);
        wait_idle("blank7");
        tick();
        frame("blank7", 7);

        // Reset mid-conversion with a pending value queued
        send(9999);
        count_in    = 14'd1234;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy0), 32'd0);
        check("mid_dig", 32'(dig0), 32'hF);
        check("mid_dat0", 32'(dat0), 32'hFF);
        check("mid_dat1", 32'(dat1), 32'hFF);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            check("post_busy", 32'(busy0), 32'd0);
            check_out("post_rst", 0);
        end

        // Random single conversions with random dots
        for (int r = 0; r < 12; r++) begin
            v      = $urandom_range(0, 16383);
            dot_in = 4'($urandom_range(0, 15));
            send(v);
            wait_idle("rand");
            tick();
            frame("rand", sat(v));
        end

        // Random bursts with random gaps; the last value sent must win
        for (int r = 0; r < 8; r++) begin
            exp_q.delete();
            nb = $urandom_range(2, 5);
            for (int j = 0; j < nb; j++) begin
                v = (j == 0 || $urandom_range(0, 1) == 1) ?
                    $urandom_range(0, 16383) : $urandom_range(0, 99);
                exp_q.push_back(32'(sat(v)));
                send(v);
                repeat ($urandom_range(0, 20)) tick();
            end
            wait_idle("burst");
            tick();
            frame("burst", int'(exp_q[$]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Display back end of the 0–9999 counter design. Takes the binary count from the counter stage and converts it to four BCD digits with a sequential double-dabble converter. Time-multiplexes those digits onto a 4-digit common-anode 7-segment display, producing the `fnd_digit` / `fnd_data` pins the top level drives off-chip.

## Interface
- `SCAN_DIV`, 100_000, clock cycles each digit stays lit (100 MHz → 1 ms/digit); simulation uses 4.
- `BLANK_LZ`, 0, 1 = blank leading zero digits; the ones digit is never blanked.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `count_in`  in  14  binary count value.
- `count_valid`  in  1  one-cycle strobe; `count_in` is sampled when this is high.
- `dot_in`  in  4  per-digit decimal point, active-high, bit 0 = ones.
- `busy`  out  1  converter not idle.
- `fnd_digit`  out  4  digit enables, active-low, bit 0 = ones; registered.
- `fnd_data`  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}; registered.

## Operation
- **Saturation:** `count_in` > 9999 is clamped to 9999 at capture.
- **Converter FSM: IDLE → CONV → LOAD.**
  - IDLE + `count_valid`: load binary, clear shift/BCD registers, go to CONV.
  - CONV: 14 cycles. Each cycle, every BCD nibble ≥ 5 gets +3, then shift left by 1. After the 14th cycle, go to LOAD.
  - LOAD: `bcd_disp` ← result. If `pending_v`, load the pending value and go to CONV; otherwise go to IDLE.
- **`busy`** = (state ≠ IDLE).
- **Pending slot (one deep, last-wins):**
  - `count_valid` while busy overwrites `pending`/`pending_v`.
  - `count_valid` in the same cycle as LOAD is also captured into pending.
  - No input is lost except values superseded before conversion.
- **Scan:**
  - Prescaler counts 0..`SCAN_DIV`−1.
  - At the terminal count it wraps to 0 and `digit_sel` increments mod 4 (0 = ones … 3 = thousands).
- **Output register, loaded every cycle:**
  - `fnd_digit` ← one-hot-low of `digit_sel` (0→1110, 1→1101, 2→1011, 3→0111).
  - `fnd_data[6:0]` ← segment code of the selected nibble.
  - `fnd_data[7]` ← ~`dot_in[digit_sel]`.
- **Segment codes (with dp off):** 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Nibble 10–15 → FF (unreachable; defensive).
- **Leading-zero blanking (`BLANK_LZ` = 1):**
  - A digit whose nibble and all higher nibbles are zero outputs 8'hFF, dp included.
  - The ones digit always displays.
- A `bcd_disp` update takes effect on the next output-register load, mid-digit if needed. No glitch beyond that one-cycle boundary.

## Timing
- **Reset values:**
  - `fnd_digit` = 4'b1111, `fnd_data` = 8'hFF, `busy` = 0.
  - `bcd_disp` = 0, `pending_v` = 0, prescaler = 0, `digit_sel` = 0, state = IDLE.
- **First rising edge after reset release:** `fnd_digit` = 1110, `fnd_data` = C0.
- **Latency, with `count_valid` sampled at edge E0 in IDLE:**
  - `busy` is high after E0.
  - CONV runs from edge E1 through edge E14.
  - LOAD occurs at edge E15; `bcd_disp` is valid after E15.
  - Outputs reflect the new value after E16 for the current digit.
- **Back-to-back throughput:** one conversion per 15 cycles when pending is occupied.
- **Scan timing:**
  - Each digit lit for exactly `SCAN_DIV` cycles.
  - Full frame = 4·`SCAN_DIV` cycles.
  - The prescaler runs independently of the converter.
- **Reset asserted mid-conversion or mid-scan:** everything returns to reset values immediately, asynchronously. The pending value is discarded.

## Structure
- **Package `fnd_pkg`:**
  - constants `NUM_DIGITS` = 4, `BIN_W` = 14, `MAX_COUNT` = 9999;
  - `SEG_0`..`SEG_9`, `SEG_BLANK` = 8'hFF;
  - enum `conv_state_t` {IDLE, CONV, LOAD};
  - function `bcd_to_seg`.
- **Sub-module `bin2bcd_seq`:**
  - the converter FSM plus the pending slot;
  - ports `clk`, `reset`, `bin_in`, `bin_valid`, `busy`, `bcd_out[15:0]`, `bcd_update`.
- Top of the block: prescaler, `digit_sel`, blanking, output register.

## Test plan
All scenarios use `SCAN_DIV` = 4.
1. **Reset and scan:** reset high 10 ns, then release → outputs 1111/FF during reset. After release: 1110/C0, then 1101, 1011, 0111, each held 4 cycles, repeating.
2. **Single conversion:** `count_valid` + `count_in` = 1234 → `busy` high for exactly 15 cycles. Digits then show ones 99, tens B0, hundreds A4, thousands F9.
3. **Saturation:** `count_in` = 12000 → all four digits 90; `count_in` = 16383 → same.
4. **Last-wins pending:** 5678, then 42 at E3, then 7 at E6 → 5678 is displayed, then 0007 (F8 ones, C0 others). 42 is never displayed, and `busy` stays high 30 cycles total.
5. **Blanking and dp:** `BLANK_LZ` = 1 with count 7 → digits 3..1 = FF, ones F8. Count 0 → ones C0 only. `dot_in` = 0010 with count 1234, `BLANK_LZ` = 0 → tens shows 30.
6. **Reset mid-conversion:** reset at E5 of a 9999 conversion → `busy` = 0 at once, outputs FF. After release, display 0000; no stale pending conversion starts.
